// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters and the byte-wide memory.
// slave = arbiter side, master = requester/memory side.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = `DATA_WIDTH
);
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_ack;
    logic [31:0]       o_if_inst;
    logic              i_d_req;
    logic [ADDR_W-1:0] i_d_addr;
    logic              i_d_write;
    logic [DATA_W-1:0] i_d_wdata;
    logic              o_d_gnt;
    logic [DATA_W-1:0] o_d_rdata;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_write;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_busy;

    modport slave (
        input  i_if_req, i_if_addr, i_d_req, i_d_addr, i_d_write, i_d_wdata, i_mem_rdata,
        output o_if_ack, o_if_inst, o_d_gnt, o_d_rdata, o_mem_addr, o_mem_write,
        output o_mem_wdata, o_busy
    );

    modport master (
        output i_if_req, i_if_addr, i_d_req, i_d_addr, i_d_write, i_d_wdata, i_mem_rdata,
        input  o_if_ack, o_if_inst, o_d_gnt, o_d_rdata, o_mem_addr, o_mem_write,
        input  o_mem_wdata, o_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide memory port between a locked 4-byte instruction fetch and
// single-byte data transfers. Define MEM_ARB_RR_EN for round-robin tie-breaking.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = `DATA_WIDTH,
    parameter int FETCH_BYTES = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mem_arbiter_if.slave   bus
);
    localparam int CNT_W = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FETCH_BYTES - 1);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] lane_reg [FETCH_BYTES];
    logic              ack_reg;
    logic              data_win, fetch_acc, burst_last;

    assign burst_last = (state_reg == FETCH) && (cnt_reg == LAST_CNT);

`ifdef MEM_ARB_RR_EN
    logic last_reg;  // 0 = data won last, 1 = fetch won last

    always_comb begin
        data_win  = 1'b0;
        fetch_acc = 1'b0;
        if (state_reg == IDLE) begin
            if (bus.i_d_req && bus.i_if_req) begin
                fetch_acc = ~last_reg;
                data_win  = last_reg;
            end else begin
                data_win  = bus.i_d_req;
                fetch_acc = bus.i_if_req;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       last_reg <= 1'b0;
        else if (data_win)  last_reg <= 1'b0;
        else if (fetch_acc) last_reg <= 1'b1;
    end
`else
    // Fixed data priority: the execute stage stalls during fetch, so starvation is harmless.
    always_comb begin
        data_win  = 1'b0;
        fetch_acc = 1'b0;
        if (state_reg == IDLE) begin
            data_win  = bus.i_d_req;
            fetch_acc = bus.i_if_req && !bus.i_d_req;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (fetch_acc)  state_next = FETCH;
            FETCH:   if (burst_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_mem_addr  = '0;
        bus.o_mem_write = 1'b0;
        bus.o_mem_wdata = '0;
        bus.o_d_gnt     = 1'b0;
        bus.o_d_rdata   = '0;
        bus.o_busy      = (state_reg == FETCH);
        if (state_reg == FETCH) begin
            bus.o_mem_addr = addr_reg + ADDR_W'(cnt_reg);
        end else if (data_win) begin
            bus.o_d_gnt     = 1'b1;
            bus.o_mem_addr  = bus.i_d_addr;
            bus.o_mem_write = bus.i_d_write;
            bus.o_mem_wdata = bus.i_d_wdata;
            bus.o_d_rdata   = bus.i_mem_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg  <= '0;
            addr_reg <= '0;
            ack_reg  <= 1'b0;
            for (int i = 0; i < FETCH_BYTES; i++) lane_reg[i] <= '0;
        end else begin
            ack_reg <= burst_last;
            if (fetch_acc) begin
                addr_reg <= bus.i_if_addr;
                cnt_reg  <= '0;
            end else if (state_reg == FETCH) begin
                lane_reg[cnt_reg] <= bus.i_mem_rdata;
                cnt_reg           <= burst_last ? '0 : cnt_reg + 1'b1;
            end
        end
    end

    // Little-endian assembly: byte fetched first lands in the low lane.
    for (genvar gi = 0; gi < FETCH_BYTES; gi++) begin : g_lane
        assign bus.o_if_inst[DATA_W*gi +: DATA_W] = lane_reg[gi];
    end

    assign bus.o_if_ack = ack_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of IDLE data vectors plus hand-written
// fetch, contention, address-wrap and mid-burst reset sequences.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_mem_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Memory: written bytes override a fixed preload image (low 12 address bits).
    bit [7:0] ram   [4096];
    bit       ram_v [4096];
    logic [11:0] ma;
    assign ma = bus.o_mem_addr[11:0];

    function automatic logic [7:0] rom_byte(input logic [11:0] a);
        case (a)
            12'h100: return 8'h13;
            12'h101: return 8'h05;
            12'h102: return 8'h50;
            12'h103: return 8'h00;
            12'h200: return 8'h11;
            12'h201: return 8'h22;
            12'h202: return 8'h33;
            12'h203: return 8'h44;
            12'hFFE: return 8'hAA;
            12'hFFF: return 8'hBB;
            12'h000: return 8'hCC;
            12'h001: return 8'hDD;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_mem_rdata = ram_v[ma] ? ram[ma] : rom_byte(ma);

    always @(posedge clk) begin
        if (bus.o_mem_write) begin
            ram[ma]   <= bus.o_mem_wdata;
            ram_v[ma] <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        d_req;
        logic [31:0] d_addr;
        logic        d_write;
        logic [7:0]  d_wdata;
        logic        e_gnt;
        logic [31:0] e_addr;
        logic        e_write;
        logic [7:0]  e_wdata;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic fetch_burst(input logic [31:0] addr, input logic [31:0] inst, input string tag);
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = addr;
        #1;
        chk({tag, "_accept_gnt"}, {31'd0, bus.o_d_gnt}, 32'd0);
        chk({tag, "_accept_write"}, {31'd0, bus.o_mem_write}, 32'd0);
        chk({tag, "_accept_addr"}, bus.o_mem_addr, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd1);
            chk({tag, "_addr"}, bus.o_mem_addr, addr + 32'(k));
            chk({tag, "_early_ack"}, {31'd0, bus.o_if_ack}, 32'd0);
            tick();
        end
        #1;
        chk({tag, "_ack"}, {31'd0, bus.o_if_ack}, 32'd1);
        chk({tag, "_inst"}, bus.o_if_inst, inst);
        chk({tag, "_busy_end"}, {31'd0, bus.o_busy}, 32'd0);
        bus.i_if_req = 1'b0;
        $display("fetch %s addr=0x%08h inst=0x%08h", tag, addr, bus.o_if_inst);
        tick();
        #1;
        chk({tag, "_ack_pulse"}, {31'd0, bus.o_if_ack}, 32'd0);
        chk({tag, "_inst_hold"}, bus.o_if_inst, inst);
    endtask

    initial begin
        bit ack_seen;

        bus.i_if_req  = 1'b0;
        bus.i_if_addr = '0;
        bus.i_d_req   = 1'b0;
        bus.i_d_addr  = '0;
        bus.i_d_write = 1'b0;
        bus.i_d_wdata = '0;

        vecs[0] = '{1'b0, 32'h20,  1'b1, 8'h5A, 1'b0, 32'h0,   1'b0, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 32'h20,  1'b1, 8'hA5, 1'b1, 32'h20,  1'b1, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 32'h20,  1'b0, 8'h77, 1'b1, 32'h20,  1'b0, 8'h77, 8'hA5};
        vecs[3] = '{1'b1, 32'h21,  1'b1, 8'h3C, 1'b1, 32'h21,  1'b1, 8'h3C, 8'h00};
        vecs[4] = '{1'b1, 32'h21,  1'b0, 8'h00, 1'b1, 32'h21,  1'b0, 8'h00, 8'h3C};
        vecs[5] = '{1'b1, 32'h102, 1'b0, 8'h00, 1'b1, 32'h102, 1'b0, 8'h00, 8'h50};

        // Reset state
        #2;
        chk("rst_ack", {31'd0, bus.o_if_ack}, 32'd0);
        chk("rst_inst", bus.o_if_inst, 32'd0);
        chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("rst_gnt", {31'd0, bus.o_d_gnt}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Data transfers in IDLE
        for (int i = 0; i < 6; i++) begin
            bus.i_d_req   = vecs[i].d_req;
            bus.i_d_addr  = vecs[i].d_addr;
            bus.i_d_write = vecs[i].d_write;
            bus.i_d_wdata = vecs[i].d_wdata;
            #1;
            chk("vec_gnt",   {31'd0, bus.o_d_gnt}, {31'd0, vecs[i].e_gnt});
            chk("vec_addr",  bus.o_mem_addr, vecs[i].e_addr);
            chk("vec_write", {31'd0, bus.o_mem_write}, {31'd0, vecs[i].e_write});
            chk("vec_wdata", {24'd0, bus.o_mem_wdata}, {24'd0, vecs[i].e_wdata});
            chk("vec_rdata", {24'd0, bus.o_d_rdata}, {24'd0, vecs[i].e_rdata});
            chk("vec_busy",  {31'd0, bus.o_busy}, 32'd0);
            $display("vec %0d req=%0b wr=%0b addr=0x%0h gnt=%0b rdata=0x%02h",
                     i, vecs[i].d_req, vecs[i].d_write, vecs[i].d_addr, bus.o_d_gnt, bus.o_d_rdata);
            tick();
        end
        bus.i_d_req = 1'b0;

        // Plain fetch burst
        fetch_burst(32'h100, 32'h0050_0513, "fetch100");

        // Simultaneous requests for 3 cycles (last winner is fetch here)
        bus.i_d_req   = 1'b1;
        bus.i_d_addr  = 32'h20;
        bus.i_d_write = 1'b0;
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h200;
`ifndef MEM_ARB_RR_EN
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("both_gnt", {31'd0, bus.o_d_gnt}, 32'd1);
            chk("both_rdata", {24'd0, bus.o_d_rdata}, 32'h0000_00A5);
            chk("both_busy", {31'd0, bus.o_busy}, 32'd0);
            $display("both cycle %0d gnt=%0b busy=%0b", c, bus.o_d_gnt, bus.o_busy);
            tick();
        end
        bus.i_d_req  = 1'b0;
        bus.i_if_req = 1'b0;
        #1;
        chk("both_no_fetch", {31'd0, bus.o_busy}, 32'd0);
        tick();
`else
        #1;
        chk("rr_first_gnt", {31'd0, bus.o_d_gnt}, 32'd1);
        tick();
        #1;
        chk("rr_second_gnt", {31'd0, bus.o_d_gnt}, 32'd0);
        chk("rr_second_busy", {31'd0, bus.o_busy}, 32'd0);
        tick();
        #1;
        chk("rr_fetch_busy", {31'd0, bus.o_busy}, 32'd1);
        chk("rr_fetch_gnt", {31'd0, bus.o_d_gnt}, 32'd0);
        ack_seen = 1'b0;
        for (int c = 0; c < 8 && !ack_seen; c++) begin
            tick();
            #1;
            ack_seen = bus.o_if_ack;
        end
        chk("rr_fetch_ack", {31'd0, ack_seen}, 32'd1);
        chk("rr_fetch_inst", bus.o_if_inst, 32'h4433_2211);
        $display("rr contention done ack=%0b inst=0x%08h", ack_seen, bus.o_if_inst);
        bus.i_d_req  = 1'b0;
        bus.i_if_req = 1'b0;
        tick();
`endif

        // Data request raised in the 2nd fetch cycle waits for the ack cycle
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h200;
        tick();
        #1;
        chk("dwait_addr0", bus.o_mem_addr, 32'h200);
        tick();
        bus.i_d_req   = 1'b1;
        bus.i_d_addr  = 32'h21;
        bus.i_d_write = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("dwait_gnt", {31'd0, bus.o_d_gnt}, 32'd0);
            chk("dwait_rdata", {24'd0, bus.o_d_rdata}, 32'd0);
            chk("dwait_addr", bus.o_mem_addr, 32'h200 + 32'(k));
            tick();
        end
        #1;
        chk("dwait_ack", {31'd0, bus.o_if_ack}, 32'd1);
        chk("dwait_ack_gnt", {31'd0, bus.o_d_gnt}, 32'd1);
        chk("dwait_ack_rdata", {24'd0, bus.o_d_rdata}, 32'h0000_003C);
        chk("dwait_inst", bus.o_if_inst, 32'h4433_2211);
        $display("data-during-fetch gnt=%0b rdata=0x%02h inst=0x%08h", bus.o_d_gnt, bus.o_d_rdata, bus.o_if_inst);
        bus.i_if_req = 1'b0;
        bus.i_d_req  = 1'b0;
        tick();

        // Address wrap at the top of the address space
        fetch_burst(32'hFFFF_FFFE, 32'hDDCC_BBAA, "wrap");

        // Reset asserted during the 3rd fetch cycle
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 32'h100;
        tick();
        tick();
        tick();
        #1;
        chk("rstmid_busy_before", {31'd0, bus.o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, bus.o_busy}, 32'd0);
        chk("rstmid_inst", bus.o_if_inst, 32'd0);
        chk("rstmid_ack", {31'd0, bus.o_if_ack}, 32'd0);
        chk("rstmid_addr", bus.o_mem_addr, 32'd0);
        bus.i_if_req = 1'b0;
        tick();
        rst_n = 1'b1;
        ack_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.o_if_ack) ack_seen = 1'b1;
            tick();
        end
        chk("rstmid_no_ack", {31'd0, ack_seen}, 32'd0);
        chk("rstmid_idle", {31'd0, bus.o_busy}, 32'd0);
        $display("mid-burst reset ack_seen=%0b", ack_seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
